// File: rtl/sfx_voice_mixer.sv
// Multi-voice square-wave effect synthesiser mixed onto the codec pass-through path.
// Each voice plays a timed tone; voices are summed, saturated, registered and added to the input audio.
module sfx_voice_mixer #(
  parameter int NUM_VOICES = 2,
  parameter int CNT_W      = 19,
  parameter int DUR_W      = 26,
  parameter int AMP_W      = 24,
  parameter int SAMPLE_W   = 32
) (
  input  logic                          CLOCK_50,
  input  logic                          resetn,
  input  logic [NUM_VOICES-1:0]         trig,
  input  logic [NUM_VOICES*CNT_W-1:0]   half_period,
  input  logic [NUM_VOICES*DUR_W-1:0]   duration,
  input  logic [NUM_VOICES*AMP_W-1:0]   amplitude,
  input  logic                          mute,
  input  logic                          audio_in_available,
  input  logic                          audio_out_allowed,
  input  logic [SAMPLE_W-1:0]           left_channel_audio_in,
  input  logic [SAMPLE_W-1:0]           right_channel_audio_in,
  output logic                          read_audio_in,
  output logic                          write_audio_out,
  output logic [SAMPLE_W-1:0]           left_channel_audio_out,
  output logic [SAMPLE_W-1:0]           right_channel_audio_out,
  output logic [NUM_VOICES-1:0]         active
);

  localparam int SUM_W = SAMPLE_W + $clog2(NUM_VOICES) + 1;
  localparam logic signed [SUM_W-1:0] MIX_MAX =
    {{(SUM_W-SAMPLE_W+1){1'b0}}, {(SAMPLE_W-1){1'b1}}};
  localparam logic signed [SUM_W-1:0] MIX_MIN =
    {{(SUM_W-SAMPLE_W+1){1'b1}}, {(SAMPLE_W-1){1'b0}}};

  typedef enum logic {IDLE = 1'b0, PLAY = 1'b1} voice_state_t;

  logic signed [SAMPLE_W-1:0] voice_val [NUM_VOICES];
  logic signed [SUM_W-1:0]    mix_sum;
  logic signed [SUM_W-1:0]    mix_sat;
  logic signed [SAMPLE_W-1:0] mix_r;

  // Two's-complement add that clamps instead of wrapping.
  function automatic logic [SAMPLE_W-1:0] sat_add(input logic [SAMPLE_W-1:0] a,
                                                  input logic [SAMPLE_W-1:0] b);
    logic [SAMPLE_W:0] s;
    s = {a[SAMPLE_W-1], a} + {b[SAMPLE_W-1], b};
    if (s[SAMPLE_W] != s[SAMPLE_W-1])
      sat_add = s[SAMPLE_W] ? {1'b1, {(SAMPLE_W-1){1'b0}}} : {1'b0, {(SAMPLE_W-1){1'b1}}};
    else
      sat_add = s[SAMPLE_W-1:0];
  endfunction

  for (genvar v = 0; v < NUM_VOICES; v++) begin : g_voice
    voice_state_t               state, state_nxt;
    logic [CNT_W-1:0]           hp, tone_cnt, hp_in;
    logic [DUR_W-1:0]           dur_cnt, dur_in;
    logic [AMP_W-1:0]           amp, amp_in;
    logic                       phase;
    logic                       start;
    logic signed [SAMPLE_W-1:0] amp_ext;

    assign hp_in   = half_period[v*CNT_W +: CNT_W];
    assign dur_in  = duration[v*DUR_W +: DUR_W];
    assign amp_in  = amplitude[v*AMP_W +: AMP_W];
    assign start   = trig[v] && (dur_in != '0);
    assign amp_ext = {{(SAMPLE_W-AMP_W){1'b0}}, amp};

    always_ff @(posedge CLOCK_50 or negedge resetn) begin
      if (!resetn) state <= IDLE;
      else         state <= state_nxt;
    end

    // A valid trigger wins in either state, so a retrigger never leaves a gap cycle.
    always_comb begin
      state_nxt = state;
      case (state)
        IDLE: if (start) state_nxt = PLAY;
        PLAY: if (start) state_nxt = PLAY;
              else if (dur_cnt == DUR_W'(1)) state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end

    always_ff @(posedge CLOCK_50 or negedge resetn) begin
      if (!resetn) begin
        hp       <= '0;
        tone_cnt <= '0;
        dur_cnt  <= '0;
        amp      <= '0;
        phase    <= 1'b0;
      end else if (start) begin
        hp       <= (hp_in == '0) ? CNT_W'(1) : hp_in;
        tone_cnt <= '0;
        dur_cnt  <= dur_in;
        amp      <= amp_in;
        phase    <= 1'b0;
      end else if (state == PLAY) begin
        dur_cnt <= dur_cnt - DUR_W'(1);
        if (tone_cnt == hp - CNT_W'(1)) begin
          tone_cnt <= '0;
          phase    <= ~phase;
        end else begin
          tone_cnt <= tone_cnt + CNT_W'(1);
        end
      end
    end

    assign active[v]    = (state == PLAY);
    assign voice_val[v] = (state == PLAY && !mute) ? (phase ? -amp_ext : amp_ext) : '0;
  end

  always_comb begin
    mix_sum = '0;
    for (int v = 0; v < NUM_VOICES; v++)
      mix_sum = mix_sum + SUM_W'(voice_val[v]);
    if (mix_sum > MIX_MAX)      mix_sat = MIX_MAX;
    else if (mix_sum < MIX_MIN) mix_sat = MIX_MIN;
    else                        mix_sat = mix_sum;
  end

  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) mix_r <= '0;
    else         mix_r <= mix_sat[SAMPLE_W-1:0];
  end

  assign left_channel_audio_out  = sat_add(left_channel_audio_in, mix_r);
  assign right_channel_audio_out = sat_add(right_channel_audio_in, mix_r);
  assign read_audio_in           = audio_in_available & audio_out_allowed;
  assign write_audio_out         = audio_in_available & audio_out_allowed;

endmodule
